// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
// Package     : lc3b_types
// Description : Word/line/tag types and write-back FSM state encoding shared
//               by the eviction buffer slice.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3b_types;

    localparam int LINE_OFFSET_W = 4;
    localparam int TAG_W         = 16 - LINE_OFFSET_W;

    typedef logic [15:0]      lc3b_word;
    typedef logic [127:0]     lc3b_line;
    typedef logic [TAG_W-1:0] lc3b_tag;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE_MEM = 2'd1,
        MEM_BREAK = 2'd2
    } evict_state_e;

    // Rebuild a line-aligned byte address from a stored tag.
    function automatic lc3b_word line_addr(input lc3b_tag tag);
        return {tag, {LINE_OFFSET_W{1'b0}}};
    endfunction

endpackage

`default_nettype wire

// File: rtl/vc_evict_buffer_if.sv
`default_nettype none
// ============================================================================
// Interface   : vc_evict_buffer_if
// Description : Victim-cache eviction, probe and physical-memory write-back
//               signals of the eviction buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface vc_evict_buffer_if;
    import lc3b_types::*;

    logic     evict_write;
    lc3b_word evict_addr;
    lc3b_line evict_data;
    logic     evict_ack;
    logic     full;
    lc3b_word probe_addr;
    logic     probe_hit;
    lc3b_line probe_data;
    logic     pmem_write;
    lc3b_word pmem_address;
    lc3b_line pmem_wdata;
    logic     pmem_resp;

    // Buffer side
    modport slave (
        input  evict_write, evict_addr, evict_data, probe_addr, pmem_resp,
        output evict_ack, full, probe_hit, probe_data,
               pmem_write, pmem_address, pmem_wdata
    );

    // Victim cache / memory side
    modport master (
        output evict_write, evict_addr, evict_data, probe_addr, pmem_resp,
        input  evict_ack, full, probe_hit, probe_data,
               pmem_write, pmem_address, pmem_wdata
    );

endinterface

`default_nettype wire

// File: rtl/vc_evict_entry.sv
`default_nettype none
// ============================================================================
// Module      : vc_evict_entry
// Description : One eviction-buffer slot: valid bit, line tag and line data.
// Revision    : 1.0 - initial release
// ============================================================================
module vc_evict_entry
    import lc3b_types::*;
(
    input  wire logic     clk,
    input  wire logic     reset,
    input  wire logic     i_load,
    input  wire logic     i_merge,
    input  wire logic     i_clear,
    input  wire lc3b_tag  i_tag,
    input  wire lc3b_line i_data,
    output logic          o_valid,
    output lc3b_tag       o_tag,
    output lc3b_line      o_data
);

    logic     valid_q, valid_d;
    lc3b_tag  tag_q,   tag_d;
    lc3b_line data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (i_clear) begin
            valid_d = 1'b0;
        end
        if (i_load) begin
            valid_d = 1'b1;
            tag_d   = i_tag;
            data_d  = i_data;
        end else if (i_merge) begin
            data_d  = i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload is qualified by valid_q, so it carries no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign o_valid = valid_q;
    assign o_tag   = tag_q;
    assign o_data  = data_q;

endmodule

`default_nettype wire

// File: rtl/vc_evict_buffer.sv
`default_nettype none
// ============================================================================
// Module      : vc_evict_buffer
// Description : DEPTH-entry write-back FIFO between a victim cache and
//               physical memory, with in-place merging and a youngest-first probe.
// Revision    : 1.0 - initial release
// ============================================================================
module vc_evict_buffer
    import lc3b_types::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic        clk,
    input  wire logic        reset,
    vc_evict_buffer_if.slave bus
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [c_ptr_w-1:0] head_q, head_d;
    logic [c_ptr_w-1:0] tail_q, tail_d;
    logic [c_cnt_w-1:0] count_q, count_d;
    evict_state_e       state_q, state_d;
    logic               ack_q, ack_d;

    logic [DEPTH-1:0]   ent_valid;
    logic [DEPTH-1:0]   ent_load;
    logic [DEPTH-1:0]   ent_merge;
    logic [DEPTH-1:0]   ent_clear;
    lc3b_tag            ent_tag  [DEPTH];
    lc3b_line           ent_data [DEPTH];

    lc3b_tag            w_evict_tag;
    lc3b_tag            w_probe_tag;
    logic               w_full;
    logic               w_accept;
    logic               w_alloc;
    logic               w_deq;
    logic               w_merge_hit;
    logic [c_ptr_w-1:0] w_merge_idx;
    logic [c_ptr_w-1:0] w_merge_scan;
    logic               w_probe_hit;
    logic [c_ptr_w-1:0] w_probe_idx;
    logic [c_ptr_w-1:0] w_probe_scan;
    logic               w_unused_offset;

    assign w_evict_tag     = bus.evict_addr[15:LINE_OFFSET_W];
    assign w_probe_tag     = bus.probe_addr[15:LINE_OFFSET_W];
    assign w_unused_offset = ^{bus.evict_addr[LINE_OFFSET_W-1:0],
                               bus.probe_addr[LINE_OFFSET_W-1:0]};

    // Fullness comes from the registered count only; a dequeue on this edge
    // cannot make room for an accept on the same edge.
    assign w_full   = (count_q == c_cnt_w'(DEPTH));
    assign w_accept = bus.evict_write & ~w_full & ~reset;
    assign w_alloc  = w_accept & ~w_merge_hit;
    assign w_deq    = (state_q == WRITE_MEM) & bus.pmem_resp & ~reset;

    // The head is never a merge target: it may be on the memory bus already.
    always_comb begin
        w_merge_hit  = 1'b0;
        w_merge_idx  = '0;
        w_merge_scan = '0;
        for (int i = 1; i < DEPTH; i++) begin
            w_merge_scan = head_q + c_ptr_w'(i);
            if (ent_valid[w_merge_scan] && (ent_tag[w_merge_scan] == w_evict_tag)) begin
                w_merge_hit = 1'b1;
                w_merge_idx = w_merge_scan;
            end
        end
    end

    // Oldest to youngest; a later match overrides, so the youngest wins.
    always_comb begin
        w_probe_hit  = 1'b0;
        w_probe_idx  = '0;
        w_probe_scan = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_probe_scan = head_q + c_ptr_w'(i);
            if (ent_valid[w_probe_scan] && (ent_tag[w_probe_scan] == w_probe_tag)) begin
                w_probe_hit = 1'b1;
                w_probe_idx = w_probe_scan;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_load[i]  = w_alloc && (tail_q == c_ptr_w'(i));
            ent_merge[i] = w_accept && w_merge_hit && (w_merge_idx == c_ptr_w'(i));
            ent_clear[i] = w_deq && (head_q == c_ptr_w'(i));
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        vc_evict_entry u_entry (
            .clk     (clk),
            .reset   (reset),
            .i_load  (ent_load[gi]),
            .i_merge (ent_merge[gi]),
            .i_clear (ent_clear[gi]),
            .i_tag   (w_evict_tag),
            .i_data  (bus.evict_data),
            .o_valid (ent_valid[gi]),
            .o_tag   (ent_tag[gi]),
            .o_data  (ent_data[gi])
        );
    end

    always_comb begin
        head_d  = head_q + c_ptr_w'(w_deq);
        tail_d  = tail_q + c_ptr_w'(w_alloc);
        count_d = count_q + c_cnt_w'(w_alloc) - c_cnt_w'(w_deq);
        ack_d   = w_accept;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (count_q != '0) state_d = WRITE_MEM;
            WRITE_MEM: if (bus.pmem_resp) state_d = MEM_BREAK;
            MEM_BREAK: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= IDLE;
            ack_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            state_q <= state_d;
            ack_q   <= ack_d;
        end
    end

    // Control outputs are forced low while reset is held.
    assign bus.evict_ack    = ack_q & ~reset;
    assign bus.full         = w_full & ~reset;
    assign bus.pmem_write   = (state_q == WRITE_MEM) & ~reset;
    assign bus.pmem_address = line_addr(ent_tag[head_q]);
    assign bus.pmem_wdata   = ent_data[head_q];
    assign bus.probe_hit    = w_probe_hit & ~reset;
    assign bus.probe_data   = (w_probe_hit & ~reset) ? ent_data[w_probe_idx] : '0;

endmodule

`default_nettype wire

// File: tb/tb_vc_evict_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vc_evict_buffer
// Description : Directed and random checks of vc_evict_buffer against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vc_evict_buffer;
    import lc3b_types::*;

    localparam int DEPTH = 4;

    logic clk    = 1'b0;
    logic rst_in = 1'b1;

    vc_evict_buffer_if bus ();

    vc_evict_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (rst_in),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0]  tag;
        logic [127:0] data;
    } ent_t;

    ent_t mq[$];      // buffered lines, oldest first
    bit   m_wr;       // a memory write is outstanding for mq[0]
    int   m_gap;      // quiet cycles still owed after a completed write
    bit   m_ack;
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [127:0] LA = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
    localparam logic [127:0] LB = 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004;
    localparam logic [127:0] LC = 128'hCCCC_0001_CCCC_0002_CCCC_0003_CCCC_0004;
    localparam logic [127:0] LD = 128'hDDDD_0001_DDDD_0002_DDDD_0003_DDDD_0004;
    localparam logic [127:0] LE = 128'hEEEE_0001_EEEE_0002_EEEE_0003_EEEE_0004;
    localparam logic [127:0] LF = 128'hFFFF_0001_FFFF_0002_FFFF_0003_FFFF_0004;
    localparam logic [127:0] LG = 128'h9999_0001_9999_0002_9999_0003_9999_0004;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic         e_hit;
        logic [127:0] e_data;
        e_hit  = 1'b0;
        e_data = '0;
        if (!rst_in) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].tag == bus.probe_addr[15:4]) begin
                    e_hit  = 1'b1;
                    e_data = mq[i].data;
                    break;
                end
            end
        end
        chk1("evict_ack", bus.evict_ack, !rst_in && m_ack);
        chk1("full", bus.full, !rst_in && (mq.size() == DEPTH));
        chk1("pmem_write", bus.pmem_write, !rst_in && m_wr);
        if (!rst_in && m_wr) begin
            chk("pmem_address", 128'(bus.pmem_address), 128'({mq[0].tag, 4'h0}));
            chk("pmem_wdata", bus.pmem_wdata, mq[0].data);
        end
        chk1("probe_hit", bus.probe_hit, e_hit);
        chk("probe_data", bus.probe_data, e_data);
    endtask

    // Reference behaviour for one clock edge, from the pre-edge view.
    task automatic model_edge(input bit ew, input logic [15:0] ea, input logic [127:0] ed,
                              input bit resp);
        int   n;
        bit   merged;
        ent_t e;
        if (rst_in) begin
            mq.delete();
            m_wr  = 1'b0;
            m_gap = 0;
            m_ack = 1'b0;
        end else begin
            n     = mq.size();
            m_ack = ew && (n < DEPTH);
            if (m_ack) begin
                merged = 1'b0;
                for (int i = n - 1; i >= 1; i--) begin
                    if (mq[i].tag == ea[15:4]) begin
                        mq[i].data = ed;
                        merged     = 1'b1;
                        break;
                    end
                end
                if (!merged) begin
                    e.tag  = ea[15:4];
                    e.data = ed;
                    mq.push_back(e);
                end
            end
            if (m_wr && resp) begin
                void'(mq.pop_front());
                m_wr  = 1'b0;
                m_gap = 1;
            end else if (!m_wr) begin
                if (m_gap > 0) m_gap--;
                else if (n > 0) m_wr = 1'b1;
            end
        end
    endtask

    task automatic tick(input bit ew, input logic [15:0] ea, input logic [127:0] ed,
                        input bit resp, input logic [15:0] pa);
        bus.evict_write = ew;
        bus.evict_addr  = ea;
        bus.evict_data  = ed;
        bus.pmem_resp   = resp;
        bus.probe_addr  = pa;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge(ew, ea, ed, resp);
        #1;
    endtask

    task automatic drain(input logic [15:0] pa);
        for (int k = 0; k < 200 && (mq.size() > 0 || m_wr); k++) begin
            tick(1'b0, 16'h0, '0, 1'b1, pa);
        end
        chk("drain_done", 128'(mq.size()), 128'(0));
        tick(1'b0, 16'h0, '0, 1'b0, pa);
        tick(1'b0, 16'h0, '0, 1'b0, pa);
    endtask

    initial begin
        logic [15:0]  ra;
        logic [15:0]  rp;
        logic [127:0] rd;
        bus.evict_write = 1'b0;
        bus.evict_addr  = '0;
        bus.evict_data  = '0;
        bus.pmem_resp   = 1'b0;
        bus.probe_addr  = '0;
        @(posedge clk);
        #1;

        // Reset
        rst_in = 1'b1;
        tick(1'b1, 16'h1230, LA, 1'b1, 16'h1230);
        tick(1'b0, 16'h0, '0, 1'b0, 16'h1230);
        rst_in = 1'b0;
        chk1("reset_full", bus.full, 1'b0);
        chk1("reset_pmem_write", bus.pmem_write, 1'b0);

        // Single evict
        tick(1'b1, 16'h1230, LA, 1'b0, 16'h1230);
        chk1("single_ack", bus.evict_ack, 1'b1);
        chk1("single_probe", bus.probe_hit, 1'b1);
        tick(1'b0, 16'h0, '0, 1'b0, 16'h1230);
        chk1("single_ack_drop", bus.evict_ack, 1'b0);
        chk1("single_write", bus.pmem_write, 1'b1);
        chk("single_addr", 128'(bus.pmem_address), 128'(16'h1230));
        chk("single_data", bus.pmem_wdata, LA);
        tick(1'b0, 16'h0, '0, 1'b0, 16'h1230);
        tick(1'b0, 16'h0, '0, 1'b0, 16'h1230);
        tick(1'b0, 16'h0, '0, 1'b1, 16'h1230);
        chk1("single_break", bus.pmem_write, 1'b0);
        chk1("single_gone", bus.probe_hit, 1'b0);
        tick(1'b0, 16'h0, '0, 1'b0, 16'h1230);
        tick(1'b0, 16'h0, '0, 1'b0, 16'h1230);
        chk1("single_empty", bus.pmem_write, 1'b0);

        // Fill past capacity
        for (int k = 1; k <= 4; k++) begin
            tick(1'b1, 16'(k) << 4, {4{32'(k)}}, 1'b0, 16'h0040);
        end
        chk1("fill_full", bus.full, 1'b1);
        tick(1'b1, 16'h0050, LE, 1'b0, 16'h0050);
        tick(1'b1, 16'h0050, LE, 1'b0, 16'h0050);
        chk1("fill_refused", bus.evict_ack, 1'b0);
        tick(1'b1, 16'h0050, LE, 1'b1, 16'h0050);
        chk1("fill_same_edge", bus.evict_ack, 1'b0);
        chk1("fill_room", bus.full, 1'b0);
        tick(1'b1, 16'h0050, LE, 1'b0, 16'h0050);
        chk1("fill_fifth_ack", bus.evict_ack, 1'b1);
        drain(16'h0050);

        // Merge into a non-head entry
        tick(1'b1, 16'h0100, LA, 1'b0, 16'h0200);
        tick(1'b1, 16'h0200, LB, 1'b0, 16'h0200);
        tick(1'b1, 16'h0200, LC, 1'b0, 16'h0200);
        chk1("merge_ack", bus.evict_ack, 1'b1);
        chk("merge_probe", bus.probe_data, LC);
        tick(1'b0, 16'h0, '0, 1'b1, 16'h0200);
        tick(1'b0, 16'h0, '0, 1'b0, 16'h0200);
        tick(1'b0, 16'h0, '0, 1'b0, 16'h0200);
        chk("merge_addr", 128'(bus.pmem_address), 128'(16'h0200));
        chk("merge_data", bus.pmem_wdata, LC);
        drain(16'h0200);

        // Head-only match while writing allocates a fresh entry
        tick(1'b1, 16'h0900, LA, 1'b0, 16'h0900);
        tick(1'b0, 16'h0, '0, 1'b0, 16'h0900);
        tick(1'b1, 16'h0900, LB, 1'b0, 16'h0900);
        chk("headmatch_probe", bus.probe_data, LB);
        chk("headmatch_wdata", bus.pmem_wdata, LA);
        drain(16'h0900);

        // Probe
        tick(1'b1, 16'h0300, LD, 1'b0, 16'h0305);
        chk1("probe_hit", bus.probe_hit, 1'b1);
        chk("probe_data", bus.probe_data, LD);
        drain(16'h0305);
        chk1("probe_gone", bus.probe_hit, 1'b0);
        chk("probe_zero", bus.probe_data, 128'h0);

        // Accept and dequeue on the same edge
        tick(1'b1, 16'h0400, LE, 1'b0, 16'h0600);
        tick(1'b1, 16'h0500, LF, 1'b0, 16'h0600);
        tick(1'b1, 16'h0600, LG, 1'b1, 16'h0600);
        chk1("simul_ack", bus.evict_ack, 1'b1);
        chk1("simul_full", bus.full, 1'b0);
        tick(1'b0, 16'h0, '0, 1'b0, 16'h0600);
        tick(1'b0, 16'h0, '0, 1'b0, 16'h0600);
        chk("simul_addr1", 128'(bus.pmem_address), 128'(16'h0500));
        chk("simul_data1", bus.pmem_wdata, LF);
        tick(1'b0, 16'h0, '0, 1'b1, 16'h0600);
        tick(1'b0, 16'h0, '0, 1'b0, 16'h0600);
        tick(1'b0, 16'h0, '0, 1'b0, 16'h0600);
        chk("simul_addr2", 128'(bus.pmem_address), 128'(16'h0600));
        chk("simul_data2", bus.pmem_wdata, LG);
        drain(16'h0600);

        // Reset in the middle of a write
        tick(1'b1, 16'h0700, LA, 1'b0, 16'h0700);
        tick(1'b0, 16'h0, '0, 1'b0, 16'h0700);
        chk1("rstmid_writing", bus.pmem_write, 1'b1);
        rst_in = 1'b1;
        tick(1'b0, 16'h0, '0, 1'b0, 16'h0700);
        rst_in = 1'b0;
        chk1("rstmid_write_off", bus.pmem_write, 1'b0);
        tick(1'b0, 16'h0, '0, 1'b1, 16'h0700);
        chk1("rstmid_late_resp", bus.pmem_write, 1'b0);
        chk1("rstmid_probe", bus.probe_hit, 1'b0);
        chk1("rstmid_full", bus.full, 1'b0);
        for (int k = 0; k < 4; k++) tick(1'b0, 16'h0, '0, 1'b0, 16'h0700);

        // Random traffic over a small tag set to exercise merges and fills
        for (int c = 0; c < 1500; c++) begin
            rst_in = ($urandom_range(0, 149) == 0);
            ra = 16'h0800 | (16'($urandom_range(0, 5)) << 4) | 16'($urandom_range(0, 15));
            rp = 16'h0800 | (16'($urandom_range(0, 6)) << 4) | 16'($urandom_range(0, 15));
            rd = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick($urandom_range(0, 99) < 45, ra, rd, $urandom_range(0, 99) < 35, rp);
        end
        rst_in = 1'b0;
        drain(16'h0800);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/vc_evict_buffer.md
VC_EVICT_BUFFER -- requirements
Module: vc_evict_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of line-sized entries; legal values 2, 4 or 8.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 evict_write  input  1  victim cache presents a dirty line for write-back.
REQ-005 evict_addr  input  16  line-aligned address of the evicted line; bits [3:0] ignored.
REQ-006 evict_data  input  128  evicted line data.
REQ-007 evict_ack  output  1  one-cycle pulse; evicted line accepted or merged.
REQ-008 full  output  1  all DEPTH entries valid.
REQ-009 probe_addr  input  16  victim cache miss-path lookup address.
REQ-010 probe_hit  output  1  combinational; some valid entry matches probe_addr[15:4].
REQ-011 probe_data  output  128  combinational; data of the matching entry; zero when probe_hit=0.
REQ-012 pmem_write  output  1  write request to physical memory.
REQ-013 pmem_address  output  16  line address of the head entry, bits [3:0]=0.
REQ-014 pmem_wdata  output  128  data of the head entry.
REQ-015 pmem_resp  input  1  physical memory write complete.

Function
REQ-016 Entries form a FIFO with head and tail pointers of log2(DEPTH) bits each, plus a count of log2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
REQ-017 Accept rule: with evict_write=1 and full=0, the block captures the line on that edge and asserts evict_ack for exactly the following cycle.
REQ-018 With evict_write=1 and full=1, the block does not capture; evict_ack stays 0 and the VC holds its request.
REQ-019 full uses the registered count; a same-cycle pmem_resp does not free a slot for a same-cycle accept.
REQ-020 Merge: an accepted address matching a valid non-head entry overwrites that entry's data in place; count is unchanged and evict_ack still pulses.
REQ-021 An address matching only the head entry while the FSM is in WRITE_MEM allocates a new tail entry; it does not merge.
REQ-022 FSM states are IDLE, WRITE_MEM and MEM_BREAK.
REQ-023 IDLE -> WRITE_MEM when count>0.
REQ-024 WRITE_MEM: pmem_write=1 with head address and data held stable; on pmem_resp=1, head is dequeued and the FSM goes to MEM_BREAK.
REQ-025 MEM_BREAK: pmem_write=0 for exactly one cycle, then IDLE.
REQ-026 Minimum spacing between back-to-back writes is one idle cycle plus one IDLE cycle.
REQ-027 Probe returns the youngest matching entry; an entry stays visible to probe until the edge on which pmem_resp dequeues it.
REQ-028 Simultaneous accept and dequeue on one edge: count is unchanged and both pointers advance.
REQ-029 Outside WRITE_MEM, pmem_write=0 and pmem_address/pmem_wdata are don't-care, driven from the head entry.

Reset
REQ-030 On reset=1 at posedge clk: all valid bits clear, head=tail=0, count=0, FSM=IDLE.
REQ-031 Outputs during and after reset: evict_ack=0, full=0, pmem_write=0, probe_hit=0.
REQ-032 Reset asserted mid-WRITE_MEM abandons the write; a pmem_resp arriving after reset is ignored.
REQ-033 Data arrays are not reset.

Structure
REQ-034 lc3b_types holds lc3b_word (16 b), lc3b_line (128 b) and the FSM state enum.
REQ-035 One sub-module, vc_evict_entry, holds a single entry (valid, tag, data) with load, merge and clear controls; the module instantiates it DEPTH times.
REQ-036 Pointer, count and FSM logic live in the top module; the probe match is a combinational priority scan, youngest first.

Verification
REQ-037 Single evict: addr 0x1230, data A, pmem_resp 3 cycles after pmem_write -> ack 1 cycle later; pmem_address=0x1230, wdata=A; count returns to 0.
REQ-038 Fill: 5 evicts (0x0010..0x0050) with pmem_resp held 0 -> 4 acks; full=1; 5th unacked until the first pmem_resp, then accepted.
REQ-039 Merge: enqueue 0x0100/A, then 0x0200/B, then 0x0200/C while 0x0100 is writing -> count=2; second write carries C.
REQ-040 Probe: after enqueuing 0x0300/D, probe 0x0305 -> probe_hit=1, probe_data=D; after its pmem_resp -> probe_hit=0.
REQ-041 Simultaneous events: accept on the same edge as pmem_resp, with count=2 -> count stays 2 and FIFO order is preserved.
REQ-042 Reset mid-write: reset during WRITE_MEM -> pmem_write=0 next cycle; count=0; a late pmem_resp produces no change.
